// File: rtl/llc_req_dispatch.sv
// LLC request dispatcher: holds one request, waits until its set is not already
// in flight and the next set-table slot is free, then issues it downstream.
module llc_req_dispatch #(
  parameter int DATA_W       = 32,
  parameter int TABLE_SIZE   = 5,
  parameter int LLC_SET_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LLC_SET_BITS-1:0] in_set,
  input  logic [DATA_W-1:0]       in_data,
  output logic [LLC_SET_BITS-1:0] set_next,
  output logic                    check_set_table,
  output logic                    add_set_to_table,
  input  logic                    is_set_in_table,
  input  logic [2:0]              set_table_pointer,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LLC_SET_BITS-1:0] out_set,
  output logic [DATA_W-1:0]       out_data,
  output logic [2:0]              out_ptr,
  input  logic                    done_valid,
  input  logic [2:0]              done_ptr,
  output logic                    remove_set_from_table,
  output logic [2:0]              table_pointer_to_remove,
  output logic [7:0]              stall_cnt,
  output logic                    protocol_err
);

  // state  | meaning
  // IDLE   | ready for a new request
  // CHECK  | held request waits for set-table clearance and a free slot
  // ISSUE  | held request offered downstream until out_ready
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'(TABLE_SIZE - 1);

  state_t                  state_q, state_d;
  logic [LLC_SET_BITS-1:0] hold_set_q, hold_set_d;
  logic [DATA_W-1:0]       hold_data_q, hold_data_d;
  logic [TABLE_SIZE-1:0]   busy_q, busy_d;
  logic [7:0]              stall_cnt_q, stall_cnt_d;
  logic                    protocol_err_q, protocol_err_d;
  logic [2:0]              out_ptr_q, out_ptr_d;

  logic slot_free;
  logic grant;
  logic done_hit;

  // A slot index outside the table can never be granted or completed.
  always_comb begin
    slot_free = 1'b0;
    if (set_table_pointer <= LAST_SLOT) begin
      slot_free = !busy_q[set_table_pointer];
    end
    done_hit = 1'b0;
    if (done_valid && (done_ptr <= LAST_SLOT)) begin
      done_hit = busy_q[done_ptr];
    end
    grant = (state_q == ST_CHECK) && !is_set_in_table && slot_free;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_CHECK;
      ST_CHECK: if (grant)     state_d = ST_ISSUE;
      ST_ISSUE: if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // in_ready is gated by rst so it stays low while reset is asserted.
  always_comb begin
    in_ready                = rst && (state_q == ST_IDLE);
    check_set_table         = (state_q == ST_CHECK);
    add_set_to_table        = grant;
    out_valid               = (state_q == ST_ISSUE);
    set_next                = hold_set_q;
    out_set                 = hold_set_q;
    out_data                = hold_data_q;
    out_ptr                 = out_ptr_q;
    remove_set_from_table   = done_hit;
    table_pointer_to_remove = done_hit ? done_ptr : 3'd0;
    stall_cnt               = stall_cnt_q;
    protocol_err            = protocol_err_q;
  end

  always_comb begin
    hold_set_d     = hold_set_q;
    hold_data_d    = hold_data_q;
    busy_d         = busy_q;
    stall_cnt_d    = stall_cnt_q;
    protocol_err_d = protocol_err_q;
    out_ptr_d      = out_ptr_q;

    if ((state_q == ST_IDLE) && in_valid) begin
      hold_set_d  = in_set;
      hold_data_d = in_data;
    end

    // Grant needs a non-busy slot, so set and clear never hit the same bit.
    if (done_hit) begin
      busy_d[done_ptr] = 1'b0;
    end
    if (grant) begin
      busy_d[set_table_pointer] = 1'b1;
      out_ptr_d                 = set_table_pointer;
    end

    if ((state_q == ST_CHECK) && !grant && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    if (done_valid && !done_hit) begin
      protocol_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_set_q     <= '0;
      hold_data_q    <= '0;
      busy_q         <= '0;
      stall_cnt_q    <= 8'd0;
      protocol_err_q <= 1'b0;
      out_ptr_q      <= 3'd0;
    end else begin
      hold_set_q     <= hold_set_d;
      hold_data_q    <= hold_data_d;
      busy_q         <= busy_d;
      stall_cnt_q    <= stall_cnt_d;
      protocol_err_q <= protocol_err_d;
      out_ptr_q      <= out_ptr_d;
    end
  end

endmodule

// File: tb/tb_llc_req_dispatch.sv
// Bench for llc_req_dispatch: a behavioural set table drives the lookup inputs,
// and a slot-ownership model predicts grants, removals, stalls and errors.
module tb_llc_req_dispatch;

  localparam int DATA_W = 32;
  localparam int TS     = 5;
  localparam int SB     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SB-1:0]     in_set = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [SB-1:0]     set_next;
  logic              check_set_table;
  logic              add_set_to_table;
  logic              is_set_in_table;
  logic [2:0]        set_table_pointer;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SB-1:0]     out_set;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_ptr;
  logic              done_valid = 1'b0;
  logic [2:0]        done_ptr = '0;
  logic              remove_set_from_table;
  logic [2:0]        table_pointer_to_remove;
  logic [7:0]        stall_cnt;
  logic              protocol_err;

  always #5 clk = ~clk;

  llc_req_dispatch #(.DATA_W(DATA_W), .TABLE_SIZE(TS), .LLC_SET_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_set(in_set), .in_data(in_data),
    .set_next(set_next), .check_set_table(check_set_table),
    .add_set_to_table(add_set_to_table), .is_set_in_table(is_set_in_table),
    .set_table_pointer(set_table_pointer),
    .out_valid(out_valid), .out_ready(out_ready), .out_set(out_set),
    .out_data(out_data), .out_ptr(out_ptr),
    .done_valid(done_valid), .done_ptr(done_ptr),
    .remove_set_from_table(remove_set_from_table),
    .table_pointer_to_remove(table_pointer_to_remove),
    .stall_cnt(stall_cnt), .protocol_err(protocol_err)
  );

  // Set table environment: round-robin insert pointer, match on any valid entry.
  logic          tbl_v   [TS];
  logic [SB-1:0] tbl_set [TS];
  logic [2:0]    tbl_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TS; i++) begin
        tbl_v[i]   <= 1'b0;
        tbl_set[i] <= '0;
      end
      tbl_ptr <= 3'd0;
    end else begin
      if (remove_set_from_table) tbl_v[table_pointer_to_remove] <= 1'b0;
      if (add_set_to_table) begin
        tbl_v[tbl_ptr]   <= 1'b1;
        tbl_set[tbl_ptr] <= set_next;
        tbl_ptr          <= (tbl_ptr == 3'(TS - 1)) ? 3'd0 : tbl_ptr + 3'd1;
      end
    end
  end

  always_comb begin
    is_set_in_table = 1'b0;
    for (int i = 0; i < TS; i++) begin
      if (tbl_v[i] && (tbl_set[i] == set_next)) is_set_in_table = 1'b1;
    end
  end
  assign set_table_pointer = tbl_ptr;

  // Reference model: which slots hold in-flight requests and for which set.
  bit            mdl_busy [TS];
  logic [SB-1:0] mdl_set  [TS];
  int            mdl_next;
  int            mdl_stall;
  bit            mdl_err;
  logic [SB-1:0] mdl_hold_set;
  logic [DATA_W-1:0] mdl_hold_data;
  int            mdl_grant_slot;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < TS; i++) begin
      mdl_busy[i] = 1'b0;
      mdl_set[i]  = '0;
    end
    mdl_next       = 0;
    mdl_stall      = 0;
    mdl_err        = 1'b0;
    mdl_hold_set   = '0;
    mdl_hold_data  = '0;
    mdl_grant_slot = 0;
  endtask

  function automatic bit mdl_set_in_flight(input logic [SB-1:0] s);
    for (int i = 0; i < TS; i++) if (mdl_busy[i] && mdl_set[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit in_check, input bit dv, input int dp, output bit granted);
    bit hit;
    done_valid = dv;
    done_ptr   = dp[2:0];
    #1;
    hit     = dv && (dp < TS) && mdl_busy[dp];
    granted = in_check && !mdl_set_in_flight(mdl_hold_set) && !mdl_busy[mdl_next];
    check("remove_strobe", remove_set_from_table, hit);
    check("remove_ptr", table_pointer_to_remove, hit ? dp : 0);
    check("check_strobe", check_set_table, in_check);
    check("add_strobe", add_set_to_table, granted);
    check("stall_cnt", stall_cnt, mdl_stall);
    check("protocol_err", protocol_err, mdl_err);
    check("set_next", set_next, mdl_hold_set);
    if (hit) mdl_busy[dp] = 1'b0;
    if (dv && !hit) mdl_err = 1'b1;
    if (granted) begin
      mdl_busy[mdl_next] = 1'b1;
      mdl_set[mdl_next]  = mdl_hold_set;
      mdl_grant_slot     = mdl_next;
      mdl_next           = (mdl_next + 1) % TS;
    end else if (in_check && mdl_stall < 255) begin
      mdl_stall++;
    end
    @(posedge clk);
    @(negedge clk);
    done_valid = 1'b0;
    done_ptr   = 3'd0;
  endtask

  task automatic accept(input logic [SB-1:0] s, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_set   = s;
    in_data  = d;
    #1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid      = 1'b0;
    mdl_hold_set  = s;
    mdl_hold_data = d;
    check("in_ready_busy", in_ready, 0);
  endtask

  task automatic issue_phase(input int wait_cycles);
    bit g;
    for (int k = 0; k <= wait_cycles; k++) begin
      check("out_valid", out_valid, 1);
      check("out_set", out_set, mdl_hold_set);
      check("out_data", out_data, mdl_hold_data);
      check("out_ptr", out_ptr, mdl_grant_slot);
      check("in_ready_issue", in_ready, 0);
      out_ready = (k == wait_cycles);
      cycle(1'b0, 1'b0, 0, g);
    end
    out_ready = 1'b0;
    #1;
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic dispatch(input logic [SB-1:0] s, input int wait_cycles);
    bit g;
    accept(s, $urandom);
    cycle(1'b1, 1'b0, 0, g);
    if (!g) begin
      $display("FAIL dispatch_no_grant set=0x%0h expected an immediate grant", s);
      n_fail++;
    end else begin
      issue_phase(wait_cycles);
    end
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    done_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_check", check_set_table, 0);
    check("rst_add", add_set_to_table, 0);
    check("rst_remove", remove_set_from_table, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_err", protocol_err, 0);
    check("rst_out_ptr", out_ptr, 0);
    check("rst_set_next", set_next, 0);
    mdl_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int base;
    mdl_reset();
    @(negedge clk);
    do_reset();

    // Single request with 10 cycles of backpressure.
    dispatch(8'h12, 10);

    // Same set again stalls until slot 0 completes, plus one cycle for the late table clear.
    accept(8'h12, $urandom);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, g);
    cycle(1'b1, 1'b1, 0, g);
    cycle(1'b1, 1'b0, 0, g);
    issue_phase($urandom_range(0, 3));
    cycle(1'b0, 1'b1, 1, g);
    cycle(1'b0, 1'b0, 0, g);

    // Fill all slots from a clean table; sixth request stalls and saturates the counter.
    do_reset();
    base = $urandom_range(0, 200);
    for (int i = 0; i < TS; i++) dispatch(8'(base + i), 0);
    accept(8'(base + 5), $urandom);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, g);
    cycle(1'b1, 1'b1, 2, g);
    for (int k = 0; k < 260; k++) cycle(1'b1, 1'b0, 0, g);
    check("stall_saturated", stall_cnt, 8'hFF);
    cycle(1'b1, 1'b1, 0, g);
    cycle(1'b1, 1'b1, 1, g);
    issue_phase(0);

    // Completions for idle or out-of-range slots.
    cycle(1'b0, 1'b1, 3, g);
    cycle(1'b0, 1'b1, 3, g);
    cycle(1'b0, 1'b1, 6, g);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, g);

    // Reset while a request is being offered downstream.
    accept(8'($urandom_range(0, 255)), $urandom);
    cycle(1'b1, 1'b0, 0, g);
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    do_reset();
    dispatch(8'($urandom_range(0, 255)), 2);
    check("sticky_err_cleared", protocol_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/llc_req_dispatch.md
LLC_REQ_DISPATCH -- requirements
Module: llc_req_dispatch

Interface
REQ-001 Parameter: DATA_W, 32, width of request payload carried alongside set.
REQ-002 Parameter: TABLE_SIZE, 5, in-flight set-table slots; pointers 3 bits.
REQ-003 Port: clk  in  1  clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid / in_ready  in / out  1 / 1  upstream request handshake.
REQ-006 Port: in_set / in_data  in  LLC_SET_BITS / DATA_W  request set index and payload.
REQ-007 Port: set_next  out  LLC_SET_BITS  set presented to set table (held request's set).
REQ-008 Port: check_set_table / add_set_to_table  out  1 / 1  set-table lookup and insert strobes.
REQ-009 Port: is_set_in_table / set_table_pointer  in  1 / 3  set-table match result (combinational) and next-insert slot.
REQ-010 Port: out_valid / out_ready  out / in  1 / 1  downstream dispatch handshake.
REQ-011 Port: out_set / out_data / out_ptr  out  LLC_SET_BITS / DATA_W / 3  dispatched request and its table slot.
REQ-012 Port: done_valid / done_ptr  in  1 / 3  completion of request owning slot done_ptr.
REQ-013 Port: remove_set_from_table / table_pointer_to_remove  out  1 / 3  set-table removal strobe and slot.
REQ-014 Port: stall_cnt  out  8  saturating count of cycles spent blocked in CHECK.
REQ-015 Port: protocol_err  out  1  sticky flag, completion for a non-busy slot.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, ISSUE; one request held at a time in a hold register (set, data).
REQ-017 IDLE: in_ready=1; on in_valid capture in_set/in_data into hold register, go CHECK next cycle; in_ready=0 in CHECK and ISSUE.
REQ-018 set_next SHALL equal hold-register set in all states; check_set_table=1 only in CHECK.
REQ-019 busy[TABLE_SIZE-1:0] SHALL mark slots owned by dispatched, uncompleted requests.
REQ-020 CHECK grant condition: is_set_in_table==0 AND busy[set_table_pointer]==0.
REQ-021 On grant: add_set_to_table=1 for exactly that cycle, out_ptr latched from set_table_pointer, busy[set_table_pointer] set at the edge, go ISSUE.
REQ-022 CHECK without grant: remain CHECK, add_set_to_table=0, stall_cnt increments by 1 saturating at 255.
REQ-023 ISSUE: out_valid=1 with out_set/out_data/out_ptr stable from hold register; on out_ready go IDLE; out_valid SHALL NOT drop before out_ready.
REQ-024 Minimum request latency: accept at cycle N, add_set_to_table at N+1, out_valid from N+2.
REQ-025 done_valid with busy[done_ptr]==1: remove_set_from_table=1 and table_pointer_to_remove=done_ptr combinationally same cycle; busy[done_ptr] cleared at edge.
REQ-026 done_valid with busy[done_ptr]==0 or done_ptr>=TABLE_SIZE: remove_set_from_table=0, protocol_err set, held until reset.
REQ-027 Completion accepted in any state, including same cycle as grant; grant and clear never target same slot (grant requires slot not busy).
REQ-028 Remove and lookup in same cycle for matching set: set table still reports match, so CHECK stalls one extra cycle; no bypass.
REQ-029 All TABLE_SIZE slots busy: CHECK stalls until a completion frees the slot at set_table_pointer.
REQ-030 table_pointer_to_remove SHALL be 0 when remove_set_from_table=0.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, hold register 0, busy=0, stall_cnt=0, protocol_err=0, out_ptr=0.
REQ-032 During reset: in_ready=0, out_valid=0, check_set_table=0, add_set_to_table=0, remove_set_from_table=0; in_ready=1 first cycle after release.
REQ-033 Reset mid-operation SHALL discard held request with no handshake completion; set table reset concurrently by same rst.

Verification
REQ-034 Set 0x12 accepted cycle 0, no match, ptr 0 -> add at cycle 1, out_valid cycle 2 with out_ptr=0, busy=5'b00001.
REQ-035 Set 0x12 in flight; second 0x12 arrives -> stall_cnt counts each cycle; done_ptr=0 -> remove with ptr 0, one extra stall cycle, then grant with ptr 1.
REQ-036 Five distinct sets dispatched, none completed -> sixth stalls in CHECK; done_ptr=2 while pointer wraps to 0 -> stall continues until done_ptr=0.
REQ-037 out_ready held low 10 cycles in ISSUE -> out_valid/out_set/out_data/out_ptr stable; in_ready=0 throughout.
REQ-038 done_valid with done_ptr=3, busy[3]=0 -> remove_set_from_table=0, protocol_err=1 until rst.
REQ-039 rst asserted in ISSUE -> out_valid=0 immediately, busy=0; after release in_ready=1.
